// File: rtl/snake_move_controller.sv
// -----------------------------------------------------------------------------
// snake_move_controller
//
// Divides CLOCK into game move ticks. On each tick it samples the requested
// direction, rejects 180-degree reversals, advances the head one grid cell and
// checks whether the head has left the grid. It also owns the IDLE/RUN/OVER run
// state that the body and VGA logic downstream depend on.
//
// Ports
//   CLOCK        in   system clock, rising edge
//   RESET        in   synchronous, active-high reset
//   DIR_IN       in   requested direction: 00 right, 01 down, 10 up, 11 left
//   START        in   level; IDLE->RUN, OVER->IDLE
//   PAUSE        in   level; freezes the tick counter while in RUN
//   HEAD_X       out  current head column
//   HEAD_Y       out  current head row
//   DIR_OUT      out  direction actually applied (latched)
//   MOVE_STROBE  out  one-cycle pulse, coincident with updated HEAD_X/Y
//   GAME_OVER    out  high while in OVER
//   RUNNING      out  high while in RUN
//
// Build option
//   WRAP_AROUND_EN  toroidal grid: the head wraps at every edge, OVER is never
//                   entered and GAME_OVER is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | head parked at START_X/START_Y, counter cleared, wait for START
// RUN   | counter advancing, one head move per tick
// OVER  | head left the grid; head and counter frozen until START
// -----------------------------------------------------------------------------
module snake_move_controller #(
  parameter int TICK_DIV = 5000000,
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int START_X  = 16,
  parameter int START_Y  = 12
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic [1:0]     DIR_IN,
  input  logic           START,
  input  logic           PAUSE,
  output logic [X_W-1:0] HEAD_X,
  output logic [Y_W-1:0] HEAD_Y,
  output logic [1:0]     DIR_OUT,
  output logic           MOVE_STROBE,
  output logic           GAME_OVER,
  output logic           RUNNING
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]   X_START = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START = Y_W'(START_Y);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [1:0]       dir_q, dir_d;
  logic             strobe_q, strobe_d;

  logic [1:0]       dir_sel;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic             off_grid;

  // Opposite directions are bitwise complements (00/11, 01/10), so a reversal
  // request keeps the previously applied direction.
  assign dir_sel = ((DIR_IN ^ dir_q) == 2'b11) ? dir_q : DIR_IN;

`ifdef WRAP_AROUND_EN
  localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

  always_comb begin
    x_next   = x_q;
    y_next   = y_q;
    off_grid = 1'b0;
    case (dir_sel)
      DIR_RIGHT: x_next = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
      DIR_LEFT:  x_next = (x_q == '0) ? X_LAST : x_q - X_W'(1);
      DIR_DOWN:  y_next = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      DIR_UP:    y_next = (y_q == '0) ? Y_LAST : y_q - Y_W'(1);
      default: ;
    endcase
  end
`else
  localparam logic [X_W:0] X_MAX = (X_W + 1)'(GRID_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W + 1)'(GRID_H - 1);

  // Targets carry one extra bit so a step past the last column/row cannot
  // alias back into the grid before the bound compare.
  logic [X_W:0] x_tgt;
  logic [Y_W:0] y_tgt;

  always_comb begin
    x_tgt    = {1'b0, x_q};
    y_tgt    = {1'b0, y_q};
    off_grid = 1'b0;
    case (dir_sel)
      DIR_RIGHT: begin
        x_tgt    = {1'b0, x_q} + (X_W + 1)'(1);
        off_grid = (x_tgt > X_MAX);
      end
      DIR_LEFT: begin
        x_tgt    = {1'b0, x_q} - (X_W + 1)'(1);
        off_grid = (x_q == '0);
      end
      DIR_DOWN: begin
        y_tgt    = {1'b0, y_q} + (Y_W + 1)'(1);
        off_grid = (y_tgt > Y_MAX);
      end
      DIR_UP: begin
        y_tgt    = {1'b0, y_q} - (Y_W + 1)'(1);
        off_grid = (y_q == '0);
      end
      default: ;
    endcase
    x_next = x_tgt[X_W-1:0];
    y_next = y_tgt[Y_W-1:0];
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        x_d   = X_START;
        y_d   = Y_START;
        dir_d = DIR_RIGHT;
        if (START) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!PAUSE) begin
          if (cnt_q == CNT_TC) begin
            cnt_d = '0;
            dir_d = dir_sel;
            if (off_grid) begin
              state_d = ST_OVER;
            end else begin
              x_d      = x_next;
              y_d      = y_next;
              strobe_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (START) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          x_d     = X_START;
          y_d     = Y_START;
          dir_d   = DIR_RIGHT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= X_START;
      y_q      <= Y_START;
      dir_q    <= DIR_RIGHT;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      strobe_q <= strobe_d;
    end
  end

  assign HEAD_X      = x_q;
  assign HEAD_Y      = y_q;
  assign DIR_OUT     = dir_q;
  assign MOVE_STROBE = strobe_q;
  assign RUNNING     = (state_q == ST_RUN);
`ifdef WRAP_AROUND_EN
  assign GAME_OVER   = 1'b0;
`else
  assign GAME_OVER   = (state_q == ST_OVER);
`endif

endmodule

// File: tb/tb_snake_move_controller.sv
module tb_snake_move_controller;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [1:0] DIR_IN;
  logic       START;
  logic       PAUSE;
  logic [2:0] HEAD_X;
  logic [2:0] HEAD_Y;
  logic [1:0] DIR_OUT;
  logic       MOVE_STROBE;
  logic       GAME_OVER;
  logic       RUNNING;

  int n_checks = 0;
  int n_fail   = 0;

  snake_move_controller #(
    .TICK_DIV(4), .GRID_W(8), .GRID_H(8), .X_W(3), .Y_W(3),
    .START_X(4), .START_Y(4)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .DIR_IN(DIR_IN), .START(START), .PAUSE(PAUSE),
    .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .DIR_OUT(DIR_OUT),
    .MOVE_STROBE(MOVE_STROBE), .GAME_OVER(GAME_OVER), .RUNNING(RUNNING)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Three quiet edges then the tick edge; caller checks the tick result.
  task automatic move_tick();
    repeat (3) begin
      tick();
      check_val("no_strobe_between_ticks", MOVE_STROBE, 0);
    end
    tick();
  endtask

  task automatic check_head(input string tag, input int x, input int y, input int d);
    check_val({tag, "_x"}, HEAD_X, x);
    check_val({tag, "_y"}, HEAD_Y, y);
    check_val({tag, "_dir"}, DIR_OUT, d);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; PAUSE = 1'b0; DIR_IN = 2'b00;
    tick(); tick();
    RESET = 1'b0;
    check_head("reset", 4, 4, 0);
    check_val("reset_strobe", MOVE_STROBE, 0);
    check_val("reset_go", GAME_OVER, 0);
    check_val("reset_running", RUNNING, 0);
    tick();
    check_val("idle_hold_running", RUNNING, 0);

    // Start and first tick
    START = 1'b1;
    tick();
    START = 1'b0;
    check_val("run_entry_running", RUNNING, 1);
    check_head("run_entry", 4, 4, 0);
    move_tick();
    check_val("first_move_strobe", MOVE_STROBE, 1);
    check_head("first_move", 5, 4, 0);

    // Reversal rejected
    DIR_IN = 2'b11;
    move_tick();
    check_val("reversal_strobe", MOVE_STROBE, 1);
    check_head("reversal", 6, 4, 0);

    // Turn down
    DIR_IN = 2'b01;
    move_tick();
    check_val("turn_down_strobe", MOVE_STROBE, 1);
    check_head("turn_down", 6, 5, 1);

    // Glitch between ticks: only the tick-edge value counts
    DIR_IN = 2'b00; tick(); check_val("glitch_q1", MOVE_STROBE, 0);
    DIR_IN = 2'b01; tick(); check_val("glitch_q2", MOVE_STROBE, 0);
    DIR_IN = 2'b00; tick(); check_val("glitch_q3", MOVE_STROBE, 0);
    tick();
    check_val("glitch_strobe", MOVE_STROBE, 1);
    check_head("glitch", 7, 5, 0);

    // Right wall at x=7
    move_tick();
`ifdef WRAP_AROUND_EN
    check_val("wrap_x_strobe", MOVE_STROBE, 1);
    check_head("wrap_x", 0, 5, 0);
    check_val("wrap_x_go", GAME_OVER, 0);
    START = 1'b1; tick(); START = 1'b0;
    check_val("wrap_start_ignored", RUNNING, 1);
    RESET = 1'b1; tick(); RESET = 1'b0;
`else
    check_val("wall_strobe", MOVE_STROBE, 0);
    check_val("wall_go", GAME_OVER, 1);
    check_val("wall_running", RUNNING, 0);
    check_head("wall", 7, 5, 0);
    repeat (5) tick();
    check_val("over_frozen_go", GAME_OVER, 1);
    check_head("over_frozen", 7, 5, 0);
    START = 1'b1; tick(); START = 1'b0;
    check_val("over_to_idle_go", GAME_OVER, 0);
    check_val("over_to_idle_running", RUNNING, 0);
    check_head("over_to_idle", 4, 4, 0);
    tick();
    check_val("idle_stays_idle", RUNNING, 0);
`endif

    // Pause with counter at 2
    START = 1'b1; tick(); START = 1'b0;
    tick(); tick();
    PAUSE = 1'b1;
    repeat (10) begin
      tick();
      check_val("pause_no_strobe", MOVE_STROBE, 0);
    end
    check_val("pause_running", RUNNING, 1);
    PAUSE = 1'b0;
    tick();
    check_val("pause_release_1", MOVE_STROBE, 0);
    tick();
    check_val("pause_release_2", MOVE_STROBE, 1);
    check_head("after_pause", 5, 4, 0);
    move_tick();
    check_head("before_reset", 6, 4, 0);

    // Reset mid-RUN wins over START
    tick(); tick();
    RESET = 1'b1; START = 1'b1;
    tick();
    RESET = 1'b0; START = 1'b0;
    check_head("midrun_reset", 4, 4, 0);
    check_val("midrun_reset_running", RUNNING, 0);
    check_val("midrun_reset_strobe", MOVE_STROBE, 0);
    check_val("midrun_reset_go", GAME_OVER, 0);
    repeat (6) begin
      tick();
      check_val("post_reset_idle_strobe", MOVE_STROBE, 0);
    end
    check_val("post_reset_needs_start", RUNNING, 0);
    check_head("post_reset_idle", 4, 4, 0);

    // Up to the top wall
    DIR_IN = 2'b10;
    START = 1'b1; tick(); START = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      move_tick();
      check_val("up_strobe", MOVE_STROBE, 1);
      check_head("up", 4, 4 - i, 2);
    end
    move_tick();
`ifdef WRAP_AROUND_EN
    check_val("wrap_y_strobe", MOVE_STROBE, 1);
    check_head("wrap_y", 4, 7, 2);
    check_val("wrap_y_go", GAME_OVER, 0);
`else
    check_val("top_wall_strobe", MOVE_STROBE, 0);
    check_val("top_wall_go", GAME_OVER, 1);
    check_head("top_wall", 4, 0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
